// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO. Latency is WIDTH+2 cycles from start to done.
// There is no backpressure: start, mthi and mtlo are dropped (not queued) while busy.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] work_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;

    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quo;
    logic [WIDTH-1:0]   fix_rem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

    // op[0]=0 selects the signed variants; signed ops run on magnitudes
    assign rs_neg = ~op[0] & rs_val[WIDTH-1];
    assign rt_neg = ~op[0] & rt_val[WIDTH-1];
    assign rs_abs = rs_neg ? -rs_val : rs_val;
    assign rt_abs = rt_neg ? -rt_val : rt_val;

    // Shift-add: upper half accumulates, lower half holds the unconsumed multiplier bits
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : '0)};
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half shifts dividend out
    // and quotient bits in. Partial remainder < divisor keeps the borrow in bit WIDTH.
    assign div_shift = work_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        work_q[WIDTH-2:0], div_ok};

    assign fix_prod = neg_lo_q ? -work_q : work_q;
    assign fix_quo  = neg_lo_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign fix_rem  = neg_hi_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_q  <= '0;
                        is_div_q <= op[1];
                        if (op[1]) begin
                            work_q   <= {{WIDTH{1'b0}}, rs_abs};
                            opnd_q   <= rt_abs;
                            // divide by zero keeps the all-ones quotient unsigned
                            neg_lo_q <= (rs_neg ^ rt_neg) & (rt_val != '0);
                            neg_hi_q <= rs_neg;
                        end else begin
                            work_q   <= {{WIDTH{1'b0}}, rt_abs};
                            opnd_q   <= rs_abs;
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= rs_neg ^ rt_neg;
                        end
                    end
                end
                S_RUN: begin
                    work_q  <= is_div_q ? div_next : mul_next;
                    count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state_q == S_FIX) begin
            if (is_div_q) begin
                hi <= fix_rem;
                lo <= fix_quo;
            end else begin
                hi <= fix_prod[2*WIDTH-1:WIDTH];
                lo <= fix_prod[WIDTH-1:0];
            end
        end else if (!busy) begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed-vector bench for muldiv_hilo_unit with hand-computed HI/LO results.
module tb_muldiv_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drives start for one edge; returns #1 after the accepting edge. lat counts the start cycle as 1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic step(inout int lat);
        @(posedge clk); #1;
        lat++;
    endtask

    task automatic wait_done(inout int lat, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat;
        bit seen;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h_%h expected 0_0", hi, lo); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_multu_latency();
        int lat;
        bit seen;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_after_start: got %b expected 1", busy); end
        wait_done(lat, seen);
        checks++; if (!seen) begin errors++; $display("FAIL multu_done_timeout: got no done expected done"); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done: got %b expected 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        idle_cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_signed();
        int lat;
        bit seen;
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg3x7: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
        idle_cycle();
        launch(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFC); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== 64'h0000_0000_0000_0014) begin errors++; $display("FAIL mult_neg5xneg4: got %h_%h expected 00000000_00000014", hi, lo); end
        idle_cycle();
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7by2_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg7by2_hi: got %h expected ffffffff", hi); end
        idle_cycle();
        launch(OP_DIVU, 32'd100, 32'd7); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100by7: got %h_%h expected 00000002_0000000e", hi, lo); end
        idle_cycle();
    endtask

    task automatic test_div_corner();
        int lat;
        bit seen;
        launch(OP_DIVU, 32'd100, 32'd0); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'd100, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_by_zero: got %h_%h expected 00000064_ffffffff", hi, lo); end
        idle_cycle();
        launch(OP_DIV, 32'hFFFF_FFF8, 32'd0); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'hFFFF_FFF8, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_neg_by_zero: got %h_%h expected fffffff8_ffffffff", hi, lo); end
        idle_cycle();
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_by_neg1: got %h_%h expected 00000000_80000000", hi, lo); end
        idle_cycle();
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        bit seen;
        mthi = 1'b1; wr_data = 32'h1234; idle_cycle(); mthi = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_idle: got %h expected 00001234", hi); end
        mtlo = 1'b1; wr_data = 32'h5678; idle_cycle(); mtlo = 1'b0;
        checks++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL mtlo_idle: got %h_%h expected 00001234_00005678", hi, lo); end
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hABCD; idle_cycle(); mthi = 1'b0; mtlo = 1'b0;
        checks++; if ({hi, lo} !== {32'hABCD, 32'hABCD}) begin errors++; $display("FAIL mthi_mtlo_same: got %h_%h expected 0000abcd_0000abcd", hi, lo); end
        launch(OP_MULTU, 32'd6, 32'd7); lat = 1;
        step(lat); step(lat);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hDEAD;
        step(lat);
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if ({hi, lo} !== {32'hABCD, 32'hABCD}) begin errors++; $display("FAIL mt_while_busy: got %h_%h expected 0000abcd_0000abcd", hi, lo); end
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'h0, 32'd42}) begin errors++; $display("FAIL mt_busy_then_result: got %h_%h expected 00000000_0000002a", hi, lo); end
        idle_cycle();
        mthi = 1'b1; wr_data = 32'h777;
        launch(OP_MULTU, 32'd2, 32'd3); lat = 1;
        mthi = 1'b0;
        checks++; if (hi !== 32'h777) begin errors++; $display("FAIL start_with_mthi_write: got %h expected 00000777", hi); end
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'h0, 32'd6}) begin errors++; $display("FAIL start_with_mthi_fix: got %h_%h expected 00000000_00000006", hi, lo); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int lat;
        int extra;
        bit seen;
        launch(OP_MULTU, 32'd3, 32'd5); lat = 1;
        while (lat < 5) step(lat);
        op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
        step(lat);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL second_start_busy: got %b expected 1", busy); end
        wait_done(lat, seen);
        checks++; if (!seen || lat !== 34) begin errors++; $display("FAIL second_start_latency: got %0d expected 34", lat); end
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL second_start_result: got %h expected 0000000f", lo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            idle_cycle();
            if (done) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL second_start_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int extra;
        bit seen;
        launch(OP_MULTU, 32'hFFFF, 32'hFFFF); lat = 1;
        while (lat < 10) step(lat);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: got %h_%h expected 0_0", hi, lo); end
        @(posedge clk); #1;
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            idle_cycle();
            if (done) extra++;
        end
        checks++; if (extra !== 0 || {hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_no_done: got %0d dones hilo %h_%h expected 0 dones hilo 0_0", extra, hi, lo); end
        launch(OP_MULTU, 32'd6, 32'd7); lat = 1;
        wait_done(lat, seen);
        checks++; if (!seen || {hi, lo} !== {32'h0, 32'd42}) begin errors++; $display("FAIL abort_then_multu: got %h_%h expected 00000000_0000002a", hi, lo); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_signed();
        test_div_corner();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
